pal_test_pattern_gen: RTL and testbench
=======================================

// Module: pal_test_pattern_gen
// PURPOSE
//  Parametrised multi-mode PAL test-pattern source; next generation of the fixed colour-bar generator.
//  Consumes raster position/strobes from the PAL timing block and emits signed Y/U/V for the PAL encoder.
//  Selectable pattern: 75% bars, 100% bars, luma ramp, checkerboard, scrolling bars, flat field.
//  Mode and animation update only at frame start, so the picture never tears mid-frame.
// PARAMETERS
//  SAMPLE_WIDTH   9    signed Y/U/V width; >=9; table values are 9-bit, left-shifted by SAMPLE_WIDTH-9
//  POS_WIDTH      10   hPos/vPos width
//  H_START        77   first active pixel (left overscan)
//  BAR_WIDTH      110  pixels per bar; active width AW = 7*BAR_WIDTH
//  V_CAST_START   383  first line of castellation strip
//  V_PLUGE_START  440  first line of calibration/PLUGE strip
//  SCROLL_STEP    2    pixels per frame that scrolling bars advance
//  CHECKER_LOG2   5    checker square size = 2**CHECKER_LOG2 pixels/lines
//  RAMP_GAIN      85   ramp: y = ((hPos-H_START)*RAMP_GAIN)>>8
// PORTS
//  palClock      in   1             pixel clock; all logic on rising edge
//  resetN        in   1             asynchronous, active-low reset
//  hPos, vPos    in   POS_WIDTH     raster position from timing generator
//  blank, sync, burst, linePhase  in  1  timing strobes; delayed to match data
//  mode          in   3             0=75% bars 1=100% bars 2=ramp 3=checker 4=scroll 5=flat 6,7=black
//  flatY/U/V     in   9 signed      flat-field colour (mode 5); sampled at frame start
//  y, u, v       out  SAMPLE_WIDTH  signed component outputs
//  blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed  out 1  strobes aligned to y/u/v
//  frameCount    out  8             frames since reset; wraps 255->0
// BEHAVIOUR
//  Reset (async assert, sync release): y=u=v=0, blankDelayed=1, other strobes 0, frameCount=0,
//   latched mode=0, scrollOffset=0, flat regs=0.
//  Latency 2 clocks: stage 1 registers region, bar index, pixel offset and strobes; stage 2 looks up colour.
//   All four strobes take the same 2-cycle delay.
//  Frame start = hPos==0 && vPos==0 on input. On that cycle: latch mode and flat*, frameCount+=1,
//   scrollOffset += SCROLL_STEP modulo AW. The pixel at (0,0) already uses the new mode.
//  hPos<H_START or hPos>=H_START+AW: bar modes output the edge bar (white left / blue right), as before.
//  75% bars: white(235,0,0) yellow(169,-83,19) cyan(134,28,-117) green(112,-55,-98)
//   magenta(79,55,98) red(57,-28,117) blue(22,83,-19).
//  100% bars: white(255,0,0) yellow(226,-111,25) cyan(179,37,-156) green(149,-74,-131)
//   magenta(106,74,131) red(76,-37,156) blue(29,111,-25).
//  Modes 0/1/4, vPos>=V_CAST_START: castellations blue,black,magenta,black,cyan,black,white.
//  Modes 0/1/4, vPos>=V_PLUGE_START: -U(0,-64,0) | white(255,0,0) | +V(0,0,64) | black | PLUGE -10/0/+10.
//   Boundaries: wide bars 5*BAR_WIDTH/4; PLUGE thirds = 3*BAR_WIDTH/9.
//  Mode 4: bar index from (hPos-H_START+scrollOffset) mod AW; only the main field scrolls.
//  Mode 2: u=v=0; y clamps to 255 at the right; y=0 before H_START.
//  Mode 3: y=235 if hPos[C]^vPos[C] (C=CHECKER_LOG2) else 0; u=v=0.
//  While blank=1 the data path still runs; downstream masks it.
//  Arithmetic: subtraction in POS_WIDTH+1 signed; ramp product in POS_WIDTH+8 bits;
//   modulo is a single conditional subtract (offset<AW is invariant).
// STRUCTURE
//  pal_pattern_pkg (shared include): mode codes, both bar colour tables, castellation/PLUGE constants.
//  Sub-module pal_bar_index: (hPos, offset, wrap enable) -> 3-bit bar index + in-active flag; registered.
//  Top: frame-start detect, mode/flat latches, frameCount, scrollOffset, stage-2 colour mux.
// TESTING
//  Reset mid-frame -> next cycle y=u=v=0, blankDelayed=1, frameCount=0. After release, mode 0 at
//   (200,100) -> (169,-83,19) two clocks later.
//  Mode 0->1 driven at vPos=100: output stays 75% until (0,0); then (300,50) -> (179,37,-156).
//  Mode 4, SCROLL_STEP=2, 55 frames: offset 110, so (H_START,50) -> yellow. 385 frames -> offset 0,
//   no overflow glitch.
//  Mode 2: hPos=H_START -> y=0; hPos=H_START+400 -> y=132; hPos=H_START+769 -> y=255 (clamped).
//  Mode 3: (32,0) -> y=235; (32,32) -> y=0. Mode 5 flat=(50,-20,30) -> constant output next frame.
//  Pulse burst for 1 clock -> burstDelayed high exactly 2 clocks later for 1 clock.
//   Same check for sync, blank, linePhase. frameCount wraps 255->0.

Source files
------------

// File: rtl/pal_pattern_pkg.sv
// pal_pattern_pkg: mode codes, bar colour tables and castellation/PLUGE colours for the PAL pattern source
package pal_pattern_pkg;
  typedef enum logic [2:0] {
    MODE_BARS75  = 3'd0,
    MODE_BARS100 = 3'd1,
    MODE_RAMP    = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_SCROLL  = 3'd4,
    MODE_FLAT    = 3'd5
  } mode_e;
  typedef enum logic [1:0] {REG_MAIN, REG_CAST, REG_PLUGE} region_e;
  typedef struct packed {
    logic signed [8:0] y;
    logic signed [8:0] u;
    logic signed [8:0] v;
  } yuv_t;
  localparam yuv_t BLACK    = '{9'sd0, 9'sd0, 9'sd0};
  localparam yuv_t MINUS_U  = '{9'sd0, -9'sd64, 9'sd0};
  localparam yuv_t PLUS_V   = '{9'sd0, 9'sd0, 9'sd64};
  localparam yuv_t WHITE100 = '{9'sd255, 9'sd0, 9'sd0};
  localparam yuv_t PLUGE_LO = '{-9'sd10, 9'sd0, 9'sd0};
  localparam yuv_t PLUGE_HI = '{9'sd10, 9'sd0, 9'sd0};
  // Entry 7 is padding so every 3-bit index is in range.
  localparam yuv_t BARS75 [8] = '{
    '{9'sd235, 9'sd0, 9'sd0},
    '{9'sd169, -9'sd83, 9'sd19},
    '{9'sd134, 9'sd28, -9'sd117},
    '{9'sd112, -9'sd55, -9'sd98},
    '{9'sd79, 9'sd55, 9'sd98},
    '{9'sd57, -9'sd28, 9'sd117},
    '{9'sd22, 9'sd83, -9'sd19},
    '{9'sd0, 9'sd0, 9'sd0}
  };
  localparam yuv_t BARS100 [8] = '{
    '{9'sd255, 9'sd0, 9'sd0},
    '{9'sd226, -9'sd111, 9'sd25},
    '{9'sd179, 9'sd37, -9'sd156},
    '{9'sd149, -9'sd74, -9'sd131},
    '{9'sd106, 9'sd74, 9'sd131},
    '{9'sd76, -9'sd37, 9'sd156},
    '{9'sd29, 9'sd111, -9'sd25},
    '{9'sd0, 9'sd0, 9'sd0}
  };
  function automatic yuv_t bar_colour(input logic full, input logic [2:0] idx);
    return full ? BARS100[idx] : BARS75[idx];
  endfunction
  // Castellations mirror the bars (blue, magenta, cyan, white) with black between them.
  function automatic yuv_t cast_colour(input logic full, input logic [2:0] idx);
    return idx[0] ? BLACK : bar_colour(full, 3'd6 - idx);
  endfunction
endpackage

// File: rtl/pal_bar_index.sv
// pal_bar_index: registered bar index, active flag and active-relative pixel offset
module pal_bar_index #(
  parameter int POS_WIDTH = 10,
  parameter int H_START   = 77,
  parameter int BAR_WIDTH = 110
) (
  input  logic                        palClock,
  input  logic                        resetN,
  input  logic [POS_WIDTH-1:0]        hPos,
  input  logic [POS_WIDTH-1:0]        offset,
  input  logic                        wrapEn,
  output logic [2:0]                  idx,
  output logic                        active,
  output logic signed [POS_WIDTH:0]   x
);
  localparam int AW = 7 * BAR_WIDTH;
  logic signed [POS_WIDTH:0] xc;
  logic [POS_WIDTH:0] xs, xw;
  logic act_c;
  logic [2:0] idx_c;
  // Offset into active area, optional scroll wrap, and bar number; outside the field the edge bar repeats.
  always_comb begin
    xc = $signed({1'b0, hPos}) - $signed((POS_WIDTH+1)'(H_START));
    act_c = !xc[POS_WIDTH] && xc < $signed((POS_WIDTH+1)'(AW));
    xs = $unsigned(xc) + (wrapEn ? {1'b0, offset} : '0);
    xw = xs >= (POS_WIDTH+1)'(AW) ? xs - (POS_WIDTH+1)'(AW) : xs;
    idx_c = 3'd0;
    for (int k = 1; k < 7; k++) if (xw >= (POS_WIDTH+1)'(k * BAR_WIDTH)) idx_c = 3'(k);
    if (!act_c) idx_c = xc[POS_WIDTH] ? 3'd0 : 3'd6;
  end
  // Stage-1 register for the horizontal geometry.
  always_ff @(posedge palClock or negedge resetN) begin
    if (!resetN) begin
      idx <= 3'd0;
      active <= 1'b0;
      x <= '0;
    end else begin
      idx <= idx_c;
      active <= act_c;
      x <= xc;
    end
  end
endmodule

// File: rtl/pal_test_pattern_gen.sv
// pal_test_pattern_gen: multi-mode PAL test-pattern source, 2-clock latency Y/U/V with aligned strobes
module pal_test_pattern_gen import pal_pattern_pkg::*; #(
  parameter int SAMPLE_WIDTH  = 9,
  parameter int POS_WIDTH     = 10,
  parameter int H_START       = 77,
  parameter int BAR_WIDTH     = 110,
  parameter int V_CAST_START  = 383,
  parameter int V_PLUGE_START = 440,
  parameter int SCROLL_STEP   = 2,
  parameter int CHECKER_LOG2  = 5,
  parameter int RAMP_GAIN     = 85
) (
  input  logic                           palClock,
  input  logic                           resetN,
  input  logic [POS_WIDTH-1:0]           hPos,
  input  logic [POS_WIDTH-1:0]           vPos,
  input  logic                           blank,
  input  logic                           sync,
  input  logic                           burst,
  input  logic                           linePhase,
  input  logic [2:0]                     mode,
  input  logic signed [8:0]              flatY,
  input  logic signed [8:0]              flatU,
  input  logic signed [8:0]              flatV,
  output logic signed [SAMPLE_WIDTH-1:0] y,
  output logic signed [SAMPLE_WIDTH-1:0] u,
  output logic signed [SAMPLE_WIDTH-1:0] v,
  output logic                           blankDelayed,
  output logic                           syncDelayed,
  output logic                           burstDelayed,
  output logic                           linePhaseDelayed,
  output logic [7:0]                     frameCount
);
  localparam int AW    = 7 * BAR_WIDTH;
  localparam int WIDE  = 5 * BAR_WIDTH / 4;
  localparam int THIRD = 3 * BAR_WIDTH / 9;
  localparam int PSTART = 5 * BAR_WIDTH;
  localparam int SH    = SAMPLE_WIDTH - 9;
  logic frame_start, wrap_en;
  logic [2:0] mode_q, mode_eff, s1_mode;
  logic [POS_WIDTH-1:0] offset, offset_inc, offset_eff;
  logic [POS_WIDTH:0] offset_sum;
  yuv_t flat_q, pluge, bar_c, c;
  region_e s1_region;
  logic s1_chk, s1_active, full;
  logic [3:0] s1_strb;
  logic [2:0] s1_idx;
  logic signed [POS_WIDTH:0] s1_x;
  logic [POS_WIDTH+7:0] prod;
  logic [POS_WIDTH-1:0] ramp;
  logic signed [8:0] ramp_y;
  int xi;
  assign frame_start = hPos == '0 && vPos == '0;
  assign mode_eff = frame_start ? mode : mode_q;
  assign offset_eff = frame_start ? offset_inc : offset;
  assign wrap_en = mode_eff == MODE_SCROLL && vPos < POS_WIDTH'(V_CAST_START);
  // Next scroll offset; offset stays below AW so one conditional subtract suffices.
  always_comb begin
    offset_sum = {1'b0, offset} + (POS_WIDTH+1)'(SCROLL_STEP);
    offset_inc = offset_sum >= (POS_WIDTH+1)'(AW) ? POS_WIDTH'(offset_sum - (POS_WIDTH+1)'(AW)) : offset_sum[POS_WIDTH-1:0];
  end
  // Frame-start state: mode, flat colour, scroll offset and frame counter change only here.
  always_ff @(posedge palClock or negedge resetN) begin
    if (!resetN) begin
      mode_q <= 3'd0;
      flat_q <= BLACK;
      offset <= '0;
      frameCount <= 8'd0;
    end else if (frame_start) begin
      mode_q <= mode;
      flat_q <= '{flatY, flatU, flatV};
      offset <= offset_inc;
      frameCount <= frameCount + 8'd1;
    end
  end
  pal_bar_index #(
    .POS_WIDTH(POS_WIDTH),
    .H_START  (H_START),
    .BAR_WIDTH(BAR_WIDTH)
  ) u_bar_index (
    .palClock(palClock),
    .resetN  (resetN),
    .hPos    (hPos),
    .offset  (offset_eff),
    .wrapEn  (wrap_en),
    .idx     (s1_idx),
    .active  (s1_active),
    .x       (s1_x)
  );
  // Stage 1: vertical region, checker phase, effective mode and strobes.
  always_ff @(posedge palClock or negedge resetN) begin
    if (!resetN) begin
      s1_mode <= 3'd0;
      s1_region <= REG_MAIN;
      s1_chk <= 1'b0;
      s1_strb <= 4'b1000;
    end else begin
      s1_mode <= mode_eff;
      s1_region <= vPos >= POS_WIDTH'(V_PLUGE_START) ? REG_PLUGE : vPos >= POS_WIDTH'(V_CAST_START) ? REG_CAST : REG_MAIN;
      s1_chk <= hPos[CHECKER_LOG2] ^ vPos[CHECKER_LOG2];
      s1_strb <= {blank, sync, burst, linePhase};
    end
  end
  // Stage-2 colour selection from the stage-1 geometry.
  always_comb begin
    xi = int'(s1_x);
    prod = (POS_WIDTH+8)'(s1_x[POS_WIDTH-1:0]) * (POS_WIDTH+8)'(RAMP_GAIN);
    ramp = POS_WIDTH'(prod >> 8);
    ramp_y = s1_x[POS_WIDTH] ? 9'sd0 : ramp > POS_WIDTH'(255) ? 9'sd255 : $signed({1'b0, ramp[7:0]});
    full = s1_mode == MODE_BARS100;
    pluge = xi < WIDE ? MINUS_U : xi < 2*WIDE ? WHITE100 : xi < 3*WIDE ? PLUS_V : xi < PSTART ? BLACK :
            xi < PSTART+THIRD ? PLUGE_LO : xi < PSTART+2*THIRD ? BLACK : xi < 6*BAR_WIDTH ? PLUGE_HI : BLACK;
    bar_c = s1_active && s1_region == REG_PLUGE ? pluge :
            s1_active && s1_region == REG_CAST ? cast_colour(full, s1_idx) : bar_colour(full, s1_idx);
    c = BLACK;
    case (s1_mode)
      MODE_BARS75, MODE_BARS100, MODE_SCROLL: c = bar_c;
      MODE_RAMP:    c.y = ramp_y;
      MODE_CHECKER: c.y = s1_chk ? 9'sd235 : 9'sd0;
      MODE_FLAT:    c = flat_q;
      default:      c = BLACK;
    endcase
  end
  // Stage 2: scaled component outputs and strobes aligned with them.
  always_ff @(posedge palClock or negedge resetN) begin
    if (!resetN) begin
      y <= '0;
      u <= '0;
      v <= '0;
      {blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed} <= 4'b1000;
    end else begin
      y <= SAMPLE_WIDTH'(c.y) <<< SH;
      u <= SAMPLE_WIDTH'(c.u) <<< SH;
      v <= SAMPLE_WIDTH'(c.v) <<< SH;
      {blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed} <= s1_strb;
    end
  end
endmodule

// File: tb/tb_pal_test_pattern_gen.sv
// tb_pal_test_pattern_gen: directed checks of modes, strips, scrolling, strobes and frame counter
module tb_pal_test_pattern_gen;
  localparam int HS = 77;
  typedef struct {int h; int vv; int ey; int eu; int ev;} vec_t;
  logic palClock = 1'b0, resetN = 1'b0;
  logic [9:0] hPos = 10'd1, vPos = 10'd1;
  logic blank = 1'b0, sync = 1'b0, burst = 1'b0, linePhase = 1'b0;
  logic [2:0] mode = 3'd0;
  logic signed [8:0] flatY = '0, flatU = '0, flatV = '0;
  logic signed [8:0] y, u, v;
  logic blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed;
  logic [7:0] frameCount;
  int checks = 0, errors = 0, exp_fc = 0;

  pal_test_pattern_gen dut (
    .palClock(palClock), .resetN(resetN), .hPos(hPos), .vPos(vPos),
    .blank(blank), .sync(sync), .burst(burst), .linePhase(linePhase),
    .mode(mode), .flatY(flatY), .flatU(flatU), .flatV(flatV),
    .y(y), .u(u), .v(v),
    .blankDelayed(blankDelayed), .syncDelayed(syncDelayed),
    .burstDelayed(burstDelayed), .linePhaseDelayed(linePhaseDelayed),
    .frameCount(frameCount)
  );

  always #5 palClock = ~palClock;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic pix(input int h, input int vv);
    @(negedge palClock);
    hPos = 10'(h);
    vPos = 10'(vv);
    @(negedge palClock);
    hPos = 10'd1;
    vPos = 10'd1;
    @(negedge palClock);
  endtask

  task automatic frame_start();
    @(negedge palClock);
    hPos = 10'd0;
    vPos = 10'd0;
    @(negedge palClock);
    hPos = 10'd1;
    vPos = 10'd1;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic do_reset();
    @(negedge palClock);
    resetN = 1'b0;
    @(negedge palClock);
    resetN = 1'b1;
    exp_fc = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge palClock);
    checks++;
    if (y !== 0 || u !== 0 || v !== 0 || blankDelayed !== 1'b1 || frameCount !== 8'd0) begin
      errors++;
      $display("FAIL por_state got y=%0d u=%0d v=%0d blk=%b fc=%0d want 0 0 0 1 0", y, u, v, blankDelayed, frameCount);
    end
    resetN = 1'b1;
    mode = 3'd0;
    frame_start();
    pix(200, 100);
    checks++;
    if (y !== 169 || u !== -83 || v !== 19 || frameCount !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset_yellow got %0d/%0d/%0d fc=%0d want 169/-83/19 fc=1", y, u, v, frameCount);
    end
    @(negedge palClock);
    resetN = 1'b0;
    #2;
    checks++;
    if (y !== 0 || u !== 0 || v !== 0 || blankDelayed !== 1'b1 || frameCount !== 8'd0) begin
      errors++;
      $display("FAIL midframe_reset got y=%0d u=%0d v=%0d blk=%b fc=%0d want 0 0 0 1 0", y, u, v, blankDelayed, frameCount);
    end
    @(negedge palClock);
    resetN = 1'b1;
    exp_fc = 0;
    pix(200, 100);
    checks++;
    if (y !== 169 || u !== -83 || v !== 19) begin
      errors++;
      $display("FAIL post_reset_yellow got %0d/%0d/%0d want 169/-83/19", y, u, v);
    end
  endtask

  task automatic test_mode_switch();
    mode = 3'd1;
    pix(300, 100);
    checks++;
    if (y !== 134 || u !== 28 || v !== -117) begin
      errors++;
      $display("FAIL mode_held_midframe got %0d/%0d/%0d want 134/28/-117", y, u, v);
    end
    @(negedge palClock);
    hPos = 10'd0;
    vPos = 10'd0;
    @(negedge palClock);
    hPos = 10'd1;
    vPos = 10'd1;
    exp_fc = (exp_fc + 1) % 256;
    @(negedge palClock);
    checks++;
    if (y !== 255 || u !== 0 || v !== 0 || frameCount !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL origin_new_mode got %0d/%0d/%0d fc=%0d want 255/0/0 fc=%0d", y, u, v, frameCount, exp_fc);
    end
    pix(300, 50);
    checks++;
    if (y !== 179 || u !== 37 || v !== -156) begin
      errors++;
      $display("FAIL bars100_cyan got %0d/%0d/%0d want 179/37/-156", y, u, v);
    end
  endtask

  task automatic test_strips();
    vec_t t[14];
    t = '{
      '{HS+225, 400, 79, 55, 98},
      '{HS+115, 400, 0, 0, 0},
      '{HS+5, 383, 22, 83, -19},
      '{HS+5, 382, 235, 0, 0},
      '{HS+10, 440, 0, -64, 0},
      '{HS+150, 450, 255, 0, 0},
      '{HS+300, 450, 0, 0, 64},
      '{HS+450, 450, 0, 0, 0},
      '{HS+560, 450, -10, 0, 0},
      '{HS+640, 450, 10, 0, 0},
      '{HS+770, 100, 22, 83, -19},
      '{10, 100, 235, 0, 0},
      '{HS+109, 100, 235, 0, 0},
      '{HS+110, 100, 169, -83, 19}
    };
    mode = 3'd0;
    frame_start();
    for (int i = 0; i < 14; i++) begin
      pix(t[i].h, t[i].vv);
      checks++;
      if (y !== t[i].ey || u !== t[i].eu || v !== t[i].ev) begin
        errors++;
        $display("FAIL strips[%0d] (%0d,%0d) got %0d/%0d/%0d want %0d/%0d/%0d", i, t[i].h, t[i].vv, y, u, v, t[i].ey, t[i].eu, t[i].ev);
      end
    end
  endtask

  task automatic test_scroll();
    vec_t a[4];
    vec_t b[2];
    a = '{'{HS, 50, 169, -83, 19}, '{HS+700, 50, 235, 0, 0}, '{HS+659, 50, 22, 83, -19}, '{HS, 400, 22, 83, -19}};
    b = '{'{HS, 50, 235, 0, 0}, '{HS+110, 50, 169, -83, 19}};
    do_reset();
    mode = 3'd4;
    repeat (55) frame_start();
    for (int i = 0; i < 4; i++) begin
      pix(a[i].h, a[i].vv);
      checks++;
      if (y !== a[i].ey || u !== a[i].eu || v !== a[i].ev) begin
        errors++;
        $display("FAIL scroll110[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, y, u, v, a[i].ey, a[i].eu, a[i].ev);
      end
    end
    repeat (330) frame_start();
    for (int i = 0; i < 2; i++) begin
      pix(b[i].h, b[i].vv);
      checks++;
      if (y !== b[i].ey || u !== b[i].eu || v !== b[i].ev) begin
        errors++;
        $display("FAIL scroll_wrap[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, y, u, v, b[i].ey, b[i].eu, b[i].ev);
      end
    end
    checks++;
    if (frameCount !== 8'd129) begin
      errors++;
      $display("FAIL frames_385 got %0d want 129", frameCount);
    end
  endtask

  task automatic test_ramp();
    vec_t t[5];
    t = '{'{HS, 50, 0, 0, 0}, '{HS+400, 50, 132, 0, 0}, '{HS+769, 50, 255, 0, 0}, '{10, 50, 0, 0, 0}, '{HS+200, 300, 66, 0, 0}};
    mode = 3'd2;
    frame_start();
    for (int i = 0; i < 5; i++) begin
      pix(t[i].h, t[i].vv);
      checks++;
      if (y !== t[i].ey || u !== 0 || v !== 0) begin
        errors++;
        $display("FAIL ramp[%0d] got %0d/%0d/%0d want %0d/0/0", i, y, u, v, t[i].ey);
      end
    end
  endtask

  task automatic test_checker();
    vec_t t[5];
    t = '{'{32, 0, 235, 0, 0}, '{32, 32, 0, 0, 0}, '{0, 32, 235, 0, 0}, '{64, 5, 0, 0, 0}, '{100, 10, 235, 0, 0}};
    mode = 3'd3;
    frame_start();
    for (int i = 0; i < 5; i++) begin
      pix(t[i].h, t[i].vv);
      checks++;
      if (y !== t[i].ey || u !== 0 || v !== 0) begin
        errors++;
        $display("FAIL checker[%0d] got %0d/%0d/%0d want %0d/0/0", i, y, u, v, t[i].ey);
      end
    end
  endtask

  task automatic test_flat();
    mode = 3'd5;
    flatY = 9'sd50;
    flatU = -9'sd20;
    flatV = 9'sd30;
    frame_start();
    flatY = 9'sd1;
    flatU = 9'sd2;
    flatV = 9'sd3;
    pix(100, 200);
    checks++;
    if (y !== 50 || u !== -20 || v !== 30) begin
      errors++;
      $display("FAIL flat_a got %0d/%0d/%0d want 50/-20/30", y, u, v);
    end
    pix(HS+700, 450);
    checks++;
    if (y !== 50 || u !== -20 || v !== 30) begin
      errors++;
      $display("FAIL flat_b got %0d/%0d/%0d want 50/-20/30", y, u, v);
    end
    mode = 3'd6;
    frame_start();
    pix(200, 100);
    checks++;
    if (y !== 0 || u !== 0 || v !== 0) begin
      errors++;
      $display("FAIL mode6_black got %0d/%0d/%0d want 0/0/0", y, u, v);
    end
  endtask

  task automatic test_strobes();
    logic [3:0] want;
    for (int i = 0; i < 4; i++) begin
      want = 4'b0001 << i;
      @(negedge palClock);
      {blank, sync, burst, linePhase} = want;
      @(negedge palClock);
      {blank, sync, burst, linePhase} = 4'b0000;
      checks++;
      if ({blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed} !== 4'b0000) begin
        errors++;
        $display("FAIL strobe_early[%0d] got %b want 0000", i, {blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed});
      end
      @(negedge palClock);
      checks++;
      if ({blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed} !== want) begin
        errors++;
        $display("FAIL strobe_on[%0d] got %b want %b", i, {blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed}, want);
      end
      @(negedge palClock);
      checks++;
      if ({blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed} !== 4'b0000) begin
        errors++;
        $display("FAIL strobe_off[%0d] got %b want 0000", i, {blankDelayed, syncDelayed, burstDelayed, linePhaseDelayed});
      end
    end
  endtask

  task automatic test_frame_wrap();
    while (exp_fc != 255) frame_start();
    checks++;
    if (frameCount !== 8'd255) begin
      errors++;
      $display("FAIL fc_255 got %0d want 255", frameCount);
    end
    frame_start();
    checks++;
    if (frameCount !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap got %0d want 0", frameCount);
    end
  endtask

  initial begin
    test_reset();
    test_mode_switch();
    test_strips();
    test_scroll();
    test_ramp();
    test_checker();
    test_flat();
    test_strobes();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
